// File: rtl/adc_multi_check.sv
// Multi-channel ADC safety checker: debounced over-current, pulse width and pulse period
// limits per channel, with sticky fail flags and a combined interlock trip output.
//
// state | meaning
// IDLE  | no sample seen since reset/clear/bypass; period counter disarmed
// LOW   | last valid sample below pulse_threshold
// HIGH  | last valid sample at/above pulse_threshold; width counting
module adc_multi_check #(
    parameter int NCH      = 2,
    parameter int DW       = 16,
    parameter int CW       = 32,
    parameter int DEBOUNCE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_fail,
    input  logic              adc_bypass,
    input  logic              pulse_cw_select,
    input  logic [NCH-1:0]    adc_data_valid,
    input  logic [NCH*DW-1:0] adc_data,
    input  logic [DW-1:0]     pulse_current_limit,
    input  logic [DW-1:0]     cw_current_limit,
    input  logic [DW-1:0]     pulse_threshold,
    input  logic [CW-1:0]     pw_min,
    input  logic [CW-1:0]     pw_max,
    input  logic [CW-1:0]     period_min,
    input  logic [CW-1:0]     period_max,
    output logic [NCH-1:0]    current_fail,
    output logic [NCH-1:0]    pw_short_fail,
    output logic [NCH-1:0]    pw_long_fail,
    output logic [NCH-1:0]    rate_high_fail,
    output logic [NCH-1:0]    rate_low_fail,
    output logic              any_fail
);

    localparam int OW = $clog2(DEBOUNCE + 1);
    localparam logic [OW-1:0] DEB     = OW'(DEBOUNCE);
    localparam logic [CW-1:0] CNT_MAX = '1;

    localparam int F_CUR   = 0;
    localparam int F_SHORT = 1;
    localparam int F_LONG  = 2;
    localparam int F_RHIGH = 3;
    localparam int F_RLOW  = 4;

    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

    logic [DW-1:0] cur_limit;
    assign cur_limit = pulse_cw_select ? cw_current_limit : pulse_current_limit;

    for (genvar n = 0; n < NCH; n++) begin : g_ch
        state_t        state_q, state_d;
        logic [OW-1:0] over_q, over_d;
        logic [CW-1:0] width_q, width_d;
        logic [CW-1:0] period_q, period_d;
        logic          armed_q, armed_d;
        logic [4:0]    flags_q, flags_d, set_d;
        logic [DW-1:0] sample;
        logic          valid;
        logic          hi;
        logic [CW-1:0] width_inc;
        logic [CW-1:0] period_inc;

        assign sample     = adc_data[n*DW +: DW];
        assign valid      = adc_data_valid[n];
        assign hi         = (sample >= pulse_threshold);
        assign width_inc  = (width_q == CNT_MAX) ? width_q : width_q + CW'(1);
        assign period_inc = (period_q == CNT_MAX) ? period_q : period_q + CW'(1);

        always_comb begin
            state_d  = state_q;
            over_d   = over_q;
            width_d  = width_q;
            period_d = period_q;
            armed_d  = armed_q;
            set_d    = '0;

            if (valid) begin
                if (sample > cur_limit) begin
                    if (over_q != DEB) over_d = over_q + OW'(1);
                    if (over_d == DEB) set_d[F_CUR] = 1'b1;
                end else begin
                    over_d = '0;
                end
            end

            // period_inc is the elapsed cycle count including this one
            if (armed_q && state_q != IDLE) begin
                period_d = period_inc;
                if (period_inc > period_max) set_d[F_RLOW] = 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (valid) begin
                        period_d = '0;
                        if (hi) begin
                            state_d = HIGH;
                            width_d = CW'(1);
                            armed_d = 1'b1;
                        end else begin
                            state_d = LOW;
                            armed_d = 1'b0;
                        end
                    end
                end
                LOW: begin
                    if (valid && hi) begin
                        state_d = HIGH;
                        width_d = CW'(1);
                        if (armed_q && period_inc < period_min) set_d[F_RHIGH] = 1'b1;
                        period_d = '0;
                        armed_d  = 1'b1;
                    end
                end
                HIGH: begin
                    if (valid) begin
                        if (hi) begin
                            width_d = width_inc;
                        end else begin
                            state_d = LOW;
                            if (width_q < pw_min) set_d[F_SHORT] = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            // stuck-on detection fires on the sample that pushes width past the limit
            if (state_d == HIGH && valid && hi && width_d > pw_max) set_d[F_LONG] = 1'b1;

            if (adc_bypass || clear_fail) begin
                state_d  = IDLE;
                over_d   = '0;
                width_d  = '0;
                period_d = '0;
                armed_d  = 1'b0;
            end
            if (adc_bypass) set_d = '0;

            flags_d = (clear_fail ? 5'b0 : flags_q) | set_d;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q  <= IDLE;
                over_q   <= '0;
                width_q  <= '0;
                period_q <= '0;
                armed_q  <= 1'b0;
                flags_q  <= '0;
            end else begin
                state_q  <= state_d;
                over_q   <= over_d;
                width_q  <= width_d;
                period_q <= period_d;
                armed_q  <= armed_d;
                flags_q  <= flags_d;
            end
        end

        assign current_fail[n]   = flags_q[F_CUR];
        assign pw_short_fail[n]  = flags_q[F_SHORT];
        assign pw_long_fail[n]   = flags_q[F_LONG];
        assign rate_high_fail[n] = flags_q[F_RHIGH];
        assign rate_low_fail[n]  = flags_q[F_RLOW];
    end

    assign any_fail = |{current_fail, pw_short_fail, pw_long_fail, rate_high_fail, rate_low_fail};

endmodule
